dual_rail_exponent_tx: RTL and testbench

Clocked-to-asynchronous bridge that feeds the exponent-zero detection stage of the async square-root datapath. Accepts an (EW+1)-bit exponent over a synchronous valid/ready handshake and drives it as a dual-rail codeword using a four-phase return-to-zero protocol. It completes the handshake against the downstream completion acknowledge. It also flags stuck handshakes and counts delivered tokens.

---
 rtl/dual_rail_exponent_tx_pkg.sv | 18 +
 rtl/dual_rail_exponent_tx_sync.sv | 24 ++
 rtl/dual_rail_exponent_tx.sv | 88 ++++++++
 tb/tb_dual_rail_exponent_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dual_rail_exponent_tx_pkg.sv
// Shared definitions for the async square-root datapath: dual-rail bit type,
// exponent width and the NULL spacer.
package pa_AsyncCordic;

    localparam int EW = 7;

    typedef struct packed {
        logic data_1;
        logic data_0;
    } dual_rail_t;

    localparam dual_rail_t DR_NULL = '{data_1: 1'b0, data_0: 1'b0};

    function automatic dual_rail_t dr_encode(input logic b);
        return '{data_1: b, data_0: ~b};
    endfunction

endpackage

// File: rtl/dual_rail_exponent_tx_sync.sv
// Two-flop synchronizer for a single async level into the clk domain.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dual_rail_exponent_tx.sv
// Clocked valid/ready to four-phase RTZ dual-rail bridge for the exponent,
// with sticky phase timeout and a wrapping token counter.
module dual_rail_exponent_tx
    import pa_AsyncCordic::*;
#(
    parameter int EW          = pa_AsyncCordic::EW,
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EW:0]         in_exponent,
    output dual_rail_t [EW:0]   exponent_o,
    input  logic                ack_i,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    token_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;

    localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    state_t             r_state;
    dual_rail_t [EW:0]  r_exp;
    logic [TW-1:0]      r_phase;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_ack_s;

    sync_2ff u_ack_sync (
        .i_clk (clk),
        .i_rst (arst),
        .i_d   (ack_i),
        .o_q   (w_ack_s)
    );

    // A stale ack still high from a previous token blocks new accepts.
    assign in_ready    = (r_state == S_IDLE) && !w_ack_s && !arst;
    assign exponent_o  = r_exp;
    assign timeout_o   = r_timeout;
    assign token_cnt_o = r_cnt;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_exp     <= {(EW+1){DR_NULL}};
            r_phase   <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_phase <= '0;
                    if (in_valid && in_ready) begin
                        r_state <= S_DATA;
                        for (int i = 0; i <= EW; i++)
                            r_exp[i] <= dr_encode(in_exponent[i]);
                    end
                end
                S_DATA, S_NULL: begin
                    if ((r_state == S_DATA) == w_ack_s) begin
                        r_phase <= '0;
                        if (r_state == S_DATA) begin
                            r_state <= S_NULL;
                            r_exp   <= {(EW+1){DR_NULL}};
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        // Waiting is never abandoned; only flag it.
                        if (ACK_TIMEOUT != 0 && r_phase != TW'(ACK_TIMEOUT))
                            r_phase <= r_phase + TW'(1);
                        if (ACK_TIMEOUT != 0 && r_phase == TW'(ACK_TIMEOUT - 1))
                            r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_exp   <= {(EW+1){DR_NULL}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_rail_exponent_tx.sv
// Randomized check of the dual-rail exponent bridge against a per-bit
// encoding rule, handshake latency rules and a modular token count.
module tb_dual_rail_exponent_tx;

    localparam int EW    = 7;
    localparam int TMO   = 8;
    localparam int CNT_W = 4;
    localparam int NB    = 2 * (EW + 1);

    logic                               clk = 1'b0;
    logic                               arst;
    logic                               in_valid;
    logic                               in_ready;
    logic [EW:0]                        in_exponent;
    pa_AsyncCordic::dual_rail_t [EW:0]  exponent_o;
    logic                               ack_i;
    logic                               timeout_o;
    logic [CNT_W-1:0]                   token_cnt_o;

    int checks = 0;
    int errors = 0;
    int m_cnt  = 0;

    dual_rail_exponent_tx #(.EW(EW), .ACK_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .arst        (arst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_exponent (in_exponent),
        .exponent_o  (exponent_o),
        .ack_i       (ack_i),
        .timeout_o   (timeout_o),
        .token_cnt_o (token_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    // Expected wire image: bit i occupies [2i+1:2i], true rail high.
    function automatic logic [NB-1:0] cw(input logic [EW:0] e);
        logic [NB-1:0] v;
        for (int i = 0; i <= EW; i++) begin
            v[2*i+1] = e[i];
            v[2*i]   = !e[i];
        end
        return v;
    endfunction

    function automatic logic [NB-1:0] rails();
        logic [NB-1:0] v;
        v = exponent_o;
        return v;
    endfunction

    task automatic tick();
        int bad;
        @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i <= EW; i++)
            if (exponent_o[i].data_1 && exponent_o[i].data_0) bad++;
        chk("legal", bad, 0);
    endtask

    task automatic do_reset();
        arst = 1'b1; in_valid = 1'b1; in_exponent = 8'h3C;
        repeat (3) begin
            tick();
            chk("rst_rdy", in_ready, 0);
            chk("rst_sp", rails(), 0);
            chk("rst_tmo", timeout_o, 0);
            chk("rst_cnt", token_cnt_o, 0);
        end
        in_valid = 1'b0; arst = 1'b0; m_cnt = 0;
        #1 chk("rel_rdy", in_ready, 1);
        tick();
        chk("rel_rdy1", in_ready, 1);
    endtask

    task automatic accept(input logic [EW:0] e);
        int n = 0;
        in_valid = 1'b1; in_exponent = e;
        while (!in_ready && n < 20) begin tick(); n++; end
        chk("acc_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0; in_exponent = EW'($urandom);
        chk("cw", rails(), cw(e));
        chk("rdy_data", in_ready, 0);
    endtask

    task automatic complete(input logic [EW:0] e, input int d, input logic tmo);
        repeat (d) begin tick(); chk("hold", rails(), cw(e)); end
        ack_i = 1'b1;
        tick(); chk("cw_k", rails(), cw(e));
        tick(); chk("cw_k1", rails(), cw(e));
        tick(); chk("null", rails(), 0);
        repeat (d) begin tick(); chk("null_hold", rails(), 0); end
        ack_i = 1'b0;
        tick(); tick();
        chk("cnt_hold", token_cnt_o, m_cnt);
        chk("rdy_null", in_ready, 0);
        tick();
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        chk("cnt", token_cnt_o, m_cnt);
        chk("rdy_idle", in_ready, 1);
        chk("tmo", timeout_o, tmo);
    endtask

    initial begin
        logic [EW:0] e;
        arst = 1'b1; in_valid = 1'b0; in_exponent = '0; ack_i = 1'b0;
        do_reset();

        accept(8'h00);
        complete(8'h00, 2, 1'b0);
        accept(8'hA5);
        complete(8'hA5, 0, 1'b0);
        accept(8'hFF);
        complete(8'hFF, 0, 1'b0);

        // Enough random tokens to wrap the 4-bit counter.
        for (int t = 0; t < 20; t++) begin
            e = EW'($urandom);
            accept(e);
            complete(e, $urandom_range(0, 3), 1'b0);
        end

        do_reset();
        accept(8'h5A);
        repeat (TMO - 1) tick();
        chk("tmo_early", timeout_o, 0);
        tick();
        chk("tmo_set", timeout_o, 1);
        chk("tmo_held", rails(), cw(8'h5A));
        complete(8'h5A, 0, 1'b1);

        arst = 1'b1; ack_i = 1'b1;
        repeat (3) tick();
        arst = 1'b0;
        tick(); tick();
        chk("stale_rdy0", in_ready, 0);
        tick();
        chk("stale_rdy1", in_ready, 0);
        ack_i = 1'b0;
        tick();
        chk("stale_rdy2", in_ready, 0);
        tick();
        chk("stale_rdy3", in_ready, 1);
        m_cnt = 0;

        accept(8'hC3);
        arst = 1'b1;
        tick();
        chk("mid_sp", rails(), 0);
        chk("mid_rdy", in_ready, 0);
        chk("mid_cnt", token_cnt_o, 0);
        arst = 1'b0;
        #1 chk("mid_idle", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
